// File: rtl/aes_mix_columns_stream.sv
// aes_mix_columns_stream: iterative AES MixColumns / InvMixColumns engine.
// One 32-bit column is transformed per clock. Valid/ready streaming on both
// sides, a completed-block counter, and a synchronous abort (soft_clr).
`timescale 1ns/1ps

module aes_mix_columns_stream #(
   parameter int NCOL   = 4,
   parameter bit INV_EN = 1'b1
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                soft_clr,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [32*NCOL-1:0]  s_data,
   input  logic                s_inv,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [32*NCOL-1:0]  m_data,
   output logic                busy,
   output logic [15:0]         block_cnt
);

   localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           col;
   logic [CW-1:0]           col_sel;
   logic                    last_col;
   logic                    mode;
   logic [NCOL-1:0][31:0]   st;          // st[NCOL-1] is column 0 (MS word)
   logic [31:0]             col_new;

   // Multiply by x in GF(2^8) with the AES reduction polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One column transform; multiples come from chained xtime and XOR only.
   function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
      end
      for (int i = 0; i < 4; i++) begin
         if (inv) begin
            r[31-8*i -: 8] = (x8[i]       ^ x4[i]       ^ x2[i])            // 0E
                           ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])       // 0B
                           ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])       // 0D
                           ^ (x8[(i+3)%4] ^ a[(i+3)%4]);                    // 09
         end else begin
            r[31-8*i -: 8] = x2[i]
                           ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                           ^ a[(i+2)%4]
                           ^ a[(i+3)%4];
         end
      end
      return r;
   endfunction

   assign col_sel  = CW'(NCOL - 1) - col;
   assign last_col = (col == CW'(NCOL - 1));
   assign m_data   = st;

   // Transform of the column currently addressed by col.
   always_comb begin
      col_new = mix_col(st[col_sel], mode && INV_EN);
   end

   // State register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      // NOTE: sequential state is always written with <= so every flop samples
      // pre-edge values regardless of statement order.
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; soft_clr overrides every transition.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned
      // (which would infer a latch).
      state_nxt = state;
      if (soft_clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (s_valid)  state_nxt = COMPUTE;
            COMPUTE: if (last_col) state_nxt = DONE;
            DONE:    if (m_ready)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
         endcase
      end
   end

   // Output decode from the registered state only.
   always_comb begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      busy    = 1'b0;
      case (state)
         IDLE:    s_ready = ~ARESET;
         COMPUTE: busy    = 1'b1;
         DONE: begin
            m_valid = 1'b1;
            busy    = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: state register load/update, column index, mode, block counter.
   always_ff @(posedge ACLK or posedge ARESET) begin
      // NOTE: the state register is reset too, because m_data is this register
      // and must read zero after ARESET.
      if (ARESET) begin
         col       <= '0;
         mode      <= 1'b0;
         st        <= '0;
         block_cnt <= '0;
      end else if (!soft_clr) begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  st   <= s_data;
                  mode <= s_inv & INV_EN;
                  col  <= '0;
               end
            end
            COMPUTE: begin
               st[col_sel] <= col_new;
               col         <= col + 1'b1;
            end
            DONE: begin
               if (m_ready) block_cnt <= block_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_mix_columns_stream.sv
// Testbench for aes_mix_columns_stream: table-driven vectors plus directed
// sequences for backpressure, soft_clr, async reset, NCOL=1, INV_EN=0 and
// counter wrap.
`timescale 1ns/1ps

module tb_aes_mix_columns_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance: NCOL=4, inverse supported
   logic          soft_clr = 0, s_valid = 0, s_inv = 0, m_ready = 0;
   logic [127:0]  s_data = '0;
   logic          s_ready, m_valid, busy;
   logic [127:0]  m_data;
   logic [15:0]   block_cnt;

   // NCOL=1 instance
   logic          n1_soft_clr = 0, n1_s_valid = 0, n1_s_inv = 0, n1_m_ready = 0;
   logic [31:0]   n1_s_data = '0;
   logic          n1_s_ready, n1_m_valid, n1_busy;
   logic [31:0]   n1_m_data;
   logic [15:0]   n1_block_cnt;

   // NCOL=4 instance without the inverse datapath
   logic          ni_soft_clr = 0, ni_s_valid = 0, ni_s_inv = 0, ni_m_ready = 0;
   logic [127:0]  ni_s_data = '0;
   logic          ni_s_ready, ni_m_valid, ni_busy;
   logic [127:0]  ni_m_data;
   logic [15:0]   ni_block_cnt;

   aes_mix_columns_stream #(.NCOL(4), .INV_EN(1'b1)) u_dut (
      .ACLK(clk), .ARESET(rst), .soft_clr(soft_clr),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_inv(s_inv),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .busy(busy), .block_cnt(block_cnt)
   );

   aes_mix_columns_stream #(.NCOL(1), .INV_EN(1'b1)) u_n1 (
      .ACLK(clk), .ARESET(rst), .soft_clr(n1_soft_clr),
      .s_valid(n1_s_valid), .s_ready(n1_s_ready), .s_data(n1_s_data), .s_inv(n1_s_inv),
      .m_valid(n1_m_valid), .m_ready(n1_m_ready), .m_data(n1_m_data),
      .busy(n1_busy), .block_cnt(n1_block_cnt)
   );

   aes_mix_columns_stream #(.NCOL(4), .INV_EN(1'b0)) u_ni (
      .ACLK(clk), .ARESET(rst), .soft_clr(ni_soft_clr),
      .s_valid(ni_s_valid), .s_ready(ni_s_ready), .s_data(ni_s_data), .s_inv(ni_s_inv),
      .m_valid(ni_m_valid), .m_ready(ni_m_ready), .m_data(ni_m_data),
      .busy(ni_busy), .block_cnt(ni_block_cnt)
   );

   typedef struct {
      logic [127:0] din;
      logic         inv;
      logic [127:0] exp;
   } vec_t;

   vec_t        vecs [7];
   int          passed = 0;
   int          total  = 0;
   logic [15:0] exp_cnt = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One block through the main instance with m_ready high; latency must be 4.
   task automatic run_main(input logic [127:0] din, input logic inv,
                           input logic [127:0] exp, input string name);
      int cyc;
      check({name, " s_ready"}, s_ready, 1);
      s_valid = 1; s_data = din; s_inv = inv; m_ready = 1;
      @(posedge clk); #1;
      s_valid = 0; s_data = '0; s_inv = 0;
      cyc = 0;
      while (!m_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, cyc, 4);
      check({name, " data"}, m_data, exp);
      check({name, " busy"}, busy, 1);
      @(posedge clk); #1;
      exp_cnt++;
      check({name, " block_cnt"}, block_cnt, exp_cnt);
      check({name, " m_valid drop"}, m_valid, 0);
      check({name, " data hold"}, m_data, exp);
   endtask

   // One block through the NCOL=1 instance; latency must be 1.
   task automatic run_n1(input logic [31:0] din, input logic inv,
                         input logic [31:0] exp, input string name);
      int cyc;
      n1_s_valid = 1; n1_s_data = din; n1_s_inv = inv; n1_m_ready = 1;
      @(posedge clk); #1;
      n1_s_valid = 0;
      cyc = 0;
      while (!n1_m_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, cyc, 1);
      check({name, " data"}, n1_m_data, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc;
      int edges;
      logic [15:0] cnt_before;

      vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
      vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
      vecs[2] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
      vecs[3] = '{128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1'b1, 128'hd4d4d4d5_2d26314c_00000000_ffffffff};
      vecs[4] = '{128'hf20a225c_db135345_c6c6c6c6_d4d4d4d5, 1'b0, 128'h9fdc589d_8e4da1bc_c6c6c6c6_d5d5d7d6};
      vecs[5] = '{128'h01000000_00000080_00000000_ffffffff, 1'b0, 128'h02010103_80809b1b_00000000_ffffffff};
      vecs[6] = '{128'h01000000_00000080_00000000_ffffffff, 1'b1, 128'h0e090d0b_ecdaf741_00000000_ffffffff};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst m_valid", m_valid, 0);
      check("rst busy", busy, 0);
      check("rst m_data", m_data, 0);
      check("rst block_cnt", block_cnt, 0);
      check("rst s_ready low in reset", s_ready, 0);
      rst = 0;
      @(posedge clk); #1;
      check("rst s_ready after release", s_ready, 1);

      // Table-driven vectors
      for (int i = 0; i < 7; i++)
         run_main(vecs[i].din, vecs[i].inv, vecs[i].exp, $sformatf("vec%0d", i));

      // Backpressure: m_ready low for 10 cycles after m_valid
      s_valid = 1; s_data = 128'hd4d4d4d5_2d26314c_00000000_ffffffff; s_inv = 0; m_ready = 0;
      @(posedge clk); #1;
      s_valid = 0;
      cyc = 0;
      while (!m_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      for (int k = 0; k < 10; k++) begin
         check("bp m_valid", m_valid, 1);
         check("bp s_ready", s_ready, 0);
         check("bp data", m_data, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
         @(posedge clk); #1;
      end
      check("bp cnt held", block_cnt, exp_cnt);
      m_ready = 1;
      @(posedge clk); #1;
      exp_cnt++;
      check("bp cnt after release", block_cnt, exp_cnt);
      check("bp s_ready back", s_ready, 1);
      check("bp m_valid drop", m_valid, 0);

      // soft_clr while COMPUTE is at col 2: columns 0,1 done, column 2 untouched
      s_valid = 1; s_data = 128'hd4d4d4d5_2d26314c_d4d4d4d5_00000000; s_inv = 0;
      @(posedge clk); #1;
      s_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      soft_clr = 1;
      @(posedge clk); #1;
      soft_clr = 0;
      check("sc compute busy", busy, 0);
      check("sc compute m_valid", m_valid, 0);
      check("sc compute s_ready", s_ready, 1);
      check("sc compute cnt", block_cnt, exp_cnt);
      check("sc compute data", m_data, 128'hd5d5d7d6_4d7ebdf8_d4d4d4d5_00000000);

      // soft_clr together with s_valid in IDLE: no accept
      soft_clr = 1; s_valid = 1; s_data = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      @(posedge clk); #1;
      soft_clr = 0; s_valid = 0;
      check("sc idle busy", busy, 0);
      check("sc idle s_ready", s_ready, 1);
      check("sc idle data", m_data, 128'hd5d5d7d6_4d7ebdf8_d4d4d4d5_00000000);
      @(posedge clk); #1;
      check("sc idle still idle", busy, 0);
      check("sc idle cnt", block_cnt, exp_cnt);

      // soft_clr coinciding with the output handshake counts as abort
      s_valid = 1; s_data = vecs[0].din; s_inv = 0; m_ready = 0;
      @(posedge clk); #1;
      s_valid = 0;
      cyc = 0;
      while (!m_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("sc done m_valid", m_valid, 1);
      soft_clr = 1; m_ready = 1;
      @(posedge clk); #1;
      soft_clr = 0;
      check("sc done m_valid drop", m_valid, 0);
      check("sc done cnt", block_cnt, exp_cnt);
      check("sc done data", m_data, vecs[0].exp);

      // Async reset pulsed mid-COMPUTE, between edges
      s_valid = 1; s_data = vecs[2].din; s_inv = 0;
      @(posedge clk); #1;
      s_valid = 0;
      @(posedge clk); #3;
      rst = 1;
      #1;
      check("ar m_valid", m_valid, 0);
      check("ar busy", busy, 0);
      check("ar m_data", m_data, 0);
      check("ar block_cnt", block_cnt, 0);
      @(posedge clk); #3;
      rst = 0;
      exp_cnt = '0;
      #4;
      run_main(vecs[0].din, 1'b0, vecs[0].exp, "post reset");

      // NCOL=1
      run_n1(32'hdb135345, 1'b0, 32'h8e4da1bc, "ncol1 fwd");
      run_n1(32'h8e4da1bc, 1'b1, 32'hdb135345, "ncol1 inv");
      check("ncol1 cnt", n1_block_cnt, 2);

      // INV_EN=0: s_inv ignored
      ni_s_valid = 1; ni_s_data = vecs[0].din; ni_s_inv = 1; ni_m_ready = 1;
      @(posedge clk); #1;
      ni_s_valid = 0;
      cyc = 0;
      while (!ni_m_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("noinv latency", cyc, 4);
      check("noinv data", ni_m_data, vecs[0].exp);

      // Counter wrap: 65537 back-to-back blocks at 3 cycles each on NCOL=1
      rst = 1;
      #2;
      rst = 0;
      @(posedge clk); #1;
      n1_s_valid = 1; n1_s_data = 32'hdb135345; n1_s_inv = 0; n1_m_ready = 1;
      edges = 0;
      for (int i = 0; i < 65537; i++) begin
         cyc = 0;
         while (!n1_m_valid && cyc < 8) begin
            @(posedge clk); #1;
            edges++; cyc++;
         end
         if (cyc >= 8) begin
            check("wrap timeout", n1_m_valid, 1);
            break;
         end
         cnt_before = n1_block_cnt;
         @(posedge clk); #1;
         edges++;
         if (i == 65534) check("wrap cnt ffff", n1_block_cnt, 16'hffff);
         if (i == 65535) check("wrap cnt 0000", n1_block_cnt, 16'h0000);
      end
      n1_s_valid = 0;
      check("wrap final cnt", n1_block_cnt, 16'h0001);
      check("wrap throughput edges", edges, 3 * 65537);
      check("wrap data", n1_m_data, 32'h8e4da1bc);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
